// File: rtl/imem_loader.sv
// Byte-stream program loader: parses framed bytes, writes 16-bit words to instruction memory,
// and releases the processor from reset once the frame checksum is verified.
module imem_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] MaxWords = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StDataHi,
        StDataLo,
        StCheck,
        StDone,
        StErr
    } state_e;

    state_e      state;
    logic [7:0]  cnt_hi;
    logic [7:0]  data_hi;
    logic [7:0]  acc;
    logic [15:0] count;
    logic [15:0] index;

    logic        xfer;
    logic [15:0] count_new;
    logic [15:0] index_inc;

    always_comb begin
        xfer      = in_valid && in_ready;
        count_new = {cnt_hi, in_data};
        index_inc = index + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            cnt_hi     <= 8'd0;
            data_hi    <= 8'd0;
            acc        <= 8'd0;
            count      <= 16'd0;
            index      <= 16'd0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= 16'd0;
            imem_wdata <= 16'd0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // Every state but DONE accepts bytes; the CHECK-pass branch below overrides this.
            if (state != StDone) begin
                in_ready <= 1'b1;
            end
            if (xfer) begin
                unique case (state)
                    StIdle, StErr: begin
                        if (in_data == SYNC_BYTE) begin
                            state <= StCntHi;
                            acc   <= 8'd0;
                            index <= 16'd0;
                            error <= 1'b0;
                        end
                    end
                    StCntHi: begin
                        cnt_hi <= in_data;
                        acc    <= acc ^ in_data;
                        state  <= StCntLo;
                    end
                    StCntLo: begin
                        count <= count_new;
                        acc   <= acc ^ in_data;
                        if (count_new > MaxWords) begin
                            state <= StErr;
                            error <= 1'b1;
                        end else if (count_new == 16'd0) begin
                            state <= StCheck;
                        end else begin
                            state <= StDataHi;
                        end
                    end
                    StDataHi: begin
                        data_hi <= in_data;
                        acc     <= acc ^ in_data;
                        state   <= StDataLo;
                    end
                    StDataLo: begin
                        acc        <= acc ^ in_data;
                        imem_we    <= 1'b1;
                        imem_wdata <= {data_hi, in_data};
                        imem_addr  <= {index[14:0], 1'b0};
                        index      <= index_inc;
                        state      <= (index_inc == count) ? StCheck : StDataHi;
                    end
                    StCheck: begin
                        if (in_data == acc) begin
                            state     <= StDone;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= StErr;
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: frame loads, checksum errors, count limits,
// empty frames and reset mid-load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];

    imem_loader #(
        .MAX_WORDS(256),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Write strobe is one cycle wide, so each pulse is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte transfers.
    task automatic send(input logic [7:0] b);
        int w;
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic gap();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] chk_byte, input bit gaps);
        logic [7:0] frame [7];
        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        for (int i = 0; i < 7; i++) begin
            send(frame[i]);
            if (gaps) gap();
        end
        send(chk_byte);
        in_valid = 1'b0;
    endtask

    task automatic check_normal_writes(input string tag);
        chk({tag, "_wr_count"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk({tag, "_addr0"}, 32'(wr_addr[0]), 32'h0000);
            chk({tag, "_data0"}, 32'(wr_data[0]), 32'h1234);
            chk({tag, "_addr1"}, 32'(wr_addr[1]), 32'h0002);
            chk({tag, "_data1"}, 32'(wr_data[1]), 32'hABCD);
        end
    endtask

    initial begin
        logic [7:0] b;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", 32'(imem_wdata), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Normal load, back-to-back bytes
        send_frame(8'h42, 1'b0);
        chk("norm_done", 32'(done), 32'd1);
        chk("norm_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("norm_error", 32'(error), 32'd0);
        chk("norm_in_ready", 32'(in_ready), 32'd0);
        check_normal_writes("norm");

        // Bytes offered in DONE are not consumed
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_wr_count", 32'(wr_addr.size()), 32'd2);

        // Bad checksum, then a good frame recovers from ERR
        do_reset();
        send_frame(8'h43, 1'b0);
        chk("badchk_error", 32'(error), 32'd1);
        chk("badchk_done", 32'(done), 32'd0);
        chk("badchk_cpu_reset", 32'(cpu_reset), 32'd1);
        check_normal_writes("badchk");
        wr_addr.delete();
        wr_data.delete();
        send_frame(8'h42, 1'b0);
        chk("recover_done", 32'(done), 32'd1);
        chk("recover_error", 32'(error), 32'd0);
        check_normal_writes("recover");

        // Pre-sync garbage, then gapped frame
        do_reset();
        send(8'h00);
        gap();
        send(8'hFF);
        gap();
        send(8'h5A);
        gap();
        chk("garbage_wr_count", 32'(wr_addr.size()), 32'd0);
        send_frame(8'h42, 1'b1);
        chk("gaps_done", 32'(done), 32'd1);
        check_normal_writes("gaps");

        // Count limit: 257 rejected right after CNT_LO
        do_reset();
        send(8'hA5);
        send(8'h01);
        send(8'h01);
        in_valid = 1'b0;
        chk("over_error", 32'(error), 32'd1);
        chk("over_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk("over_wr_count", 32'(wr_addr.size()), 32'd0);

        // 256 words from ERR: word i = {i, ~i}; checksum = 01 ^ 00 ^ (256 x FF) = 01
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            send(b);
            send(~b);
        end
        send(8'h01);
        in_valid = 1'b0;
        chk("max_done", 32'(done), 32'd1);
        chk("max_error", 32'(error), 32'd0);
        chk("max_wr_count", 32'(wr_addr.size()), 32'd256);
        if (wr_addr.size() == 256) begin
            chk("max_addr0", 32'(wr_addr[0]), 32'h0000);
            chk("max_data0", 32'(wr_data[0]), 32'h00FF);
            chk("max_addr100", 32'(wr_addr[100]), 32'h00C8);
            chk("max_data100", 32'(wr_data[100]), 32'h649B);
            chk("max_addr255", 32'(wr_addr[255]), 32'h01FE);
            chk("max_data255", 32'(wr_data[255]), 32'hFF00);
        end

        // Empty frames
        do_reset();
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        in_valid = 1'b0;
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("empty_wr_count", 32'(wr_addr.size()), 32'd0);
        do_reset();
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        send(8'h01);
        in_valid = 1'b0;
        chk("empty_bad_error", 32'(error), 32'd1);
        chk("empty_bad_done", 32'(done), 32'd0);
        chk("empty_bad_wr_count", 32'(wr_addr.size()), 32'd0);

        // Reset one cycle after the third data byte
        do_reset();
        send(8'hA5);
        send(8'h00);
        send(8'h02);
        send(8'h12);
        send(8'h34);
        send(8'hAB);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk("mid_imem_we", 32'(imem_we), 32'd0);
        chk("mid_addr", 32'(imem_addr), 32'd0);
        chk("mid_wdata", 32'(imem_wdata), 32'd0);
        chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_error", 32'(error), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hCD;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("mid_wr_count", 32'(wr_addr.size()), 32'd1);
        chk("mid_after_done", 32'(done), 32'd0);
        wr_addr.delete();
        wr_data.delete();
        send_frame(8'h42, 1'b0);
        chk("fresh_done", 32'(done), 32'd1);
        check_normal_writes("fresh");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the writer side of the processor's instruction memory.
- Accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words high byte first, and writes them to consecutive instruction-memory byte addresses 0, 2, 4, ...
- Holds the processor in reset until a complete frame passes its checksum, then releases it.

Parameters:
- MAX_WORDS, 256: maximum instruction words per frame; larger counts are rejected.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can take a byte; a byte transfers when in_valid && in_ready at the rising edge.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  16  byte address for the write, always even.
- imem_wdata  output  16  instruction word to write.
- cpu_reset  output  1  processor reset, active-high.
- done  output  1  frame loaded and checksum good.
- error  output  1  frame rejected.

Behaviour:
- Reset is synchronous, active-high and single clock. It has priority over all activity and may arrive mid-frame.
- Values during and immediately after reset:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - state=IDLE, word index=0, checksum accumulator=0.
- Frame format, in order:
  - SYNC_BYTE.
  - CNT_HI, then CNT_LO, giving N = {CNT_HI,CNT_LO} words.
  - 2N data bytes, each word sent high byte then low byte.
  - CHK = XOR of CNT_HI, CNT_LO and all data bytes.
- State transitions (each advance happens only on a transferred byte):
  - IDLE: in_ready=1. SYNC_BYTE -> CNT_HI and clears accumulator and word index. Any other byte is discarded, state stays IDLE.
  - CNT_HI: latch the byte, fold it into the accumulator -> CNT_LO.
  - CNT_LO: latch and fold. If N > MAX_WORDS -> ERR. If N == 0 -> CHECK. Otherwise -> DATA_HI.
  - DATA_HI: hold the byte as the high half, fold -> DATA_LO.
  - DATA_LO: fold. In the next cycle assert imem_we=1 with imem_wdata={hi,lo} and imem_addr=index<<1, then increment index. If index+1 == N -> CHECK, else -> DATA_HI.
  - CHECK: compare the byte with the accumulator. Equal -> DONE. Unequal -> ERR.
  - DONE: in_ready=0, done=1, cpu_reset=0. Terminal until reset.
  - ERR: error=1, cpu_reset=1, in_ready=1. SYNC_BYTE clears error and restarts at CNT_HI. Other bytes are discarded.
- Timing and handshake:
  - in_ready stays 1 in every receiving state, including the imem_we cycle. The write uses registered data, so back-to-back bytes (in_valid held high) sustain 1 byte/cycle with no stalls.
  - imem_we is high for exactly one cycle per word. imem_addr and imem_wdata hold their last values when imem_we=0.
  - done/cpu_reset change in the cycle after the CHK byte transfers. The final imem_we (from the last DATA_LO) precedes that, so every write lands before cpu_reset falls.
  - Bytes offered while in_ready=0 are not consumed.
- Width rules: the index counter is 16 bits, and imem_addr = {index[14:0],1'b0}, so the 16-bit address never exceeds MAX_WORDS*2-2.
- Boundary conditions:
  - N == MAX_WORDS is accepted.
  - N == MAX_WORDS+1 is rejected before any write is issued.
- Reset mid-frame: the partial frame is abandoned. No imem_we is issued after reset. The next frame writes from address 0 again.

Test Plan:
- Normal load: bytes A5 00 02 12 34 AB CD 42, in_valid held high.
  - Writes (addr 0x0000, 0x1234) then (0x0002, 0xABCD), exactly 2 imem_we pulses.
  - Then done=1 and cpu_reset=0 one cycle after 0x42 transfers.
- Bad checksum: the same frame with CHK=0x43.
  - Both writes occur, error=1, cpu_reset stays 1, done=0.
  - A following correct frame clears error and ends with done=1.
- Pre-sync garbage and gaps: 00 FF 5A, then the normal frame with in_valid toggling every other cycle.
  - Garbage is ignored, writes are identical to the normal load, done=1.
- Count limit with MAX_WORDS=256:
  - A5 01 01 -> error=1 immediately after CNT_LO, zero imem_we pulses.
  - A5 01 00, followed by 512 data bytes and the correct CHK -> 256 writes, last at addr 0x01FE, done=1.
- Empty frame: A5 00 00 00 -> done=1, no writes. A5 00 00 01 -> error=1.
- Reset mid-load: assert reset one cycle after the third data byte of a 2-word frame.
  - All outputs return to reset values, no further imem_we.
  - A fresh normal frame writes from addr 0x0000.
